// File: rtl/btn_debouncer.sv
// rtl/btn_debouncer.sv - pushbutton synchronizer, debounce FSM and press counter
// Defining BTN_AUTOREPEAT_EN adds auto-repeat pulses while the button stays held.
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       btn_press_pulse,
    output logic [7:0] press_count
);

    localparam logic [23:0] DEB_LAST = 24'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 16777215 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("btn_debouncer: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t      state;
    logic [23:0] deb_cnt;
    logic        sync_meta;
    logic        sync_q;
    logic        btn_sync;
    logic        press_evt;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [31:0] DELAY_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

    logic [31:0] rep_cnt;
    logic        rep_running;
`endif

    // The raw input is active-low, so the released state of the flops is 1.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync_meta <= 1'b1;
            sync_q    <= 1'b1;
        end else begin
            sync_meta <= btn_raw;
            sync_q    <= sync_meta;
        end
    end

    assign btn_sync = ~sync_q;

    // Outputs are decoded from the state one edge after it settles, giving
    // the DEBOUNCE_CYCLES+2 edge latency from the raw pin.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state           <= IDLE;
            deb_cnt         <= '0;
            press_evt       <= 1'b0;
            btn_level       <= 1'b0;
            btn_press_pulse <= 1'b0;
            press_count     <= '0;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt         <= '0;
            rep_running     <= 1'b0;
`endif
        end else begin
            press_evt       <= 1'b0;
            btn_level       <= (state == HELD) || (state == RELEASE_WAIT);
            btn_press_pulse <= press_evt;
            press_count     <= press_count + {7'd0, btn_press_pulse};

            case (state)
                IDLE: begin
                    if (btn_sync) begin
                        state   <= PRESS_WAIT;
                        deb_cnt <= 24'd1;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_sync) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= HELD;
                        deb_cnt   <= '0;
                        press_evt <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + 24'd1;
                    end
                end
                HELD: begin
                    if (!btn_sync) begin
                        state   <= RELEASE_WAIT;
                        deb_cnt <= 24'd1;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_sync) begin
                        state   <= HELD;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + 24'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    deb_cnt <= '0;
                end
            endcase

`ifdef BTN_AUTOREPEAT_EN
            // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
            if (state == HELD && btn_sync) begin
                if (rep_cnt == (rep_running ? PERIOD_LAST : DELAY_LAST)) begin
                    rep_cnt     <= '0;
                    rep_running <= 1'b1;
                    press_evt   <= 1'b1;
                end else begin
                    rep_cnt <= rep_cnt + 32'd1;
                end
            end else begin
                rep_cnt     <= '0;
                rep_running <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_btn_debouncer.sv
// tb/tb_btn_debouncer.sv - randomized self-checking bench for btn_debouncer
module tb_btn_debouncer;

    localparam int DEB  = 4;
    localparam int RDLY = 10;
    localparam int RPER = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic       btn_level;
    logic       btn_press_pulse;
    logic [7:0] press_count;

    int errors = 0;
    int checks = 0;

    // Reference model: accepted level flips after DEB consecutive opposite samples.
    bit         m_s1, m_s2, m_acc, m_evt, m_level, m_pulse;
    int         m_run, m_hold;
    logic [7:0] m_count;

    always #5 clk = ~clk;

    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDLY),
        .REPEAT_PERIOD  (RPER)
    ) dut (
        .clk_clk        (clk),
        .reset_reset    (rst),
        .btn_raw        (btn_raw),
        .btn_level      (btn_level),
        .btn_press_pulse(btn_press_pulse),
        .press_count    (press_count)
    );

    task automatic model_clear();
        m_s1 = 0; m_s2 = 0; m_acc = 0; m_evt = 0; m_level = 0; m_pulse = 0;
        m_run = 0; m_hold = 0; m_count = 8'd0;
    endtask

    task automatic step(input bit raw);
        bit sampled, was_held;
        btn_raw = raw;
        @(posedge clk);
        sampled  = m_s2;
        m_s2     = m_s1;
        m_s1     = !raw;
        m_count  = m_count + 8'(m_pulse);
        m_pulse  = m_evt;
        m_level  = m_acc;
        m_evt    = 0;
        was_held = m_acc && (m_run == 0);
        if (sampled != m_acc) begin
            m_run++;
            if (m_run == DEB) begin
                m_acc = sampled;
                m_run = 0;
                m_evt = sampled;
            end
        end else begin
            m_run = 0;
        end
`ifdef BTN_AUTOREPEAT_EN
        if (was_held && sampled) begin
            m_hold++;
            if (m_hold >= RDLY && (m_hold - RDLY) % RPER == 0) m_evt = 1;
        end else begin
            m_hold = 0;
        end
`else
        m_hold = was_held ? 0 : 0;
`endif
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        btn_raw = 1'b1;
        do_reset();
        checks++;
        if ({btn_level, btn_press_pulse, press_count} !== 10'd0) begin
            errors++;
            $display("FAIL reset_state got lvl=%b pls=%b cnt=%0d exp 0/0/0", btn_level, btn_press_pulse, press_count);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            checks++;
            if ({btn_level, btn_press_pulse, press_count} !== 10'd0) begin
                errors++;
                $display("FAIL reset_idle step=%0d got lvl=%b pls=%b cnt=%0d exp 0/0/0", i, btn_level, btn_press_pulse, press_count);
            end
        end
    endtask

    task automatic test_clean_press();
        btn_raw = 1'b1;
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            step(1'b0);
            checks++;
            if ({btn_level, btn_press_pulse, press_count} !== {m_level, m_pulse, m_count}) begin
                errors++;
                $display("FAIL clean_model step=%0d got %b/%b/%0d exp %b/%b/%0d", i, btn_level, btn_press_pulse, press_count, m_level, m_pulse, m_count);
            end
            if (i <= 15) begin
                checks++;
                if (btn_level !== (i >= 7) || btn_press_pulse !== (i == 7) || press_count !== ((i >= 8) ? 8'd1 : 8'd0)) begin
                    errors++;
                    $display("FAIL clean_edges edge=%0d got %b/%b/%0d exp %b/%b/%0d", i - 1, btn_level, btn_press_pulse, press_count, i >= 7, i == 7, (i >= 8) ? 1 : 0);
                end
            end
        end
        for (int j = 1; j <= 10; j++) begin
            step(1'b1);
            checks++;
            if (btn_level !== (j < 7)) begin
                errors++;
                $display("FAIL release_level step=%0d got %b exp %b", j, btn_level, j < 7);
            end
            checks++;
            if ({btn_level, btn_press_pulse, press_count} !== {m_level, m_pulse, m_count}) begin
                errors++;
                $display("FAIL release_model step=%0d got %b/%b/%0d exp %b/%b/%0d", j, btn_level, btn_press_pulse, press_count, m_level, m_pulse, m_count);
            end
        end
    endtask

    task automatic test_glitch();
        btn_raw = 1'b1;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(i < 3 ? 1'b0 : 1'b1);
            checks++;
            if (btn_level !== 1'b0 || btn_press_pulse !== 1'b0) begin
                errors++;
                $display("FAIL glitch step=%0d got lvl=%b pls=%b exp 0/0", i, btn_level, btn_press_pulse);
            end
        end
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL glitch_count got %0d exp 0", press_count);
        end
    endtask

    task automatic test_bounce();
        int pulses, pulse_step;
        btn_raw = 1'b1;
        do_reset();
        pulses = 0;
        pulse_step = -1;
        for (int i = 1; i <= 24; i++) begin
            step((i <= 12) ? bit'(((i - 1) / 2) % 2) : 1'b0);
            if (btn_press_pulse === 1'b1) begin
                pulses++;
                pulse_step = i;
            end
            checks++;
            if ({btn_level, btn_press_pulse, press_count} !== {m_level, m_pulse, m_count}) begin
                errors++;
                $display("FAIL bounce_model step=%0d got %b/%b/%0d exp %b/%b/%0d", i, btn_level, btn_press_pulse, press_count, m_level, m_pulse, m_count);
            end
        end
        checks++;
        if (pulses != 1 || pulse_step != 19) begin
            errors++;
            $display("FAIL bounce_pulse got pulses=%0d at_step=%0d exp 1 at_step=19", pulses, pulse_step);
        end
    endtask

    task automatic test_reset_mid_hold();
        int pulses;
        btn_raw = 1'b1;
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({btn_level, btn_press_pulse, press_count} !== 10'd0) begin
            errors++;
            $display("FAIL midhold_async_clear got %b/%b/%0d exp 0/0/0", btn_level, btn_press_pulse, press_count);
        end
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0);
            if (btn_press_pulse === 1'b1) pulses++;
            checks++;
            if ({btn_level, btn_press_pulse, press_count} !== {m_level, m_pulse, m_count}) begin
                errors++;
                $display("FAIL midhold_model step=%0d got %b/%b/%0d exp %b/%b/%0d", i, btn_level, btn_press_pulse, press_count, m_level, m_pulse, m_count);
            end
        end
        checks++;
        if (pulses != 1 || press_count !== 8'd1) begin
            errors++;
            $display("FAIL midhold_repress got pulses=%0d cnt=%0d exp 1/1", pulses, press_count);
        end
    endtask

    task automatic test_wrap();
        int bad;
        btn_raw = 1'b1;
        do_reset();
        bad = 0;
        for (int p = 1; p <= 256; p++) begin
            for (int i = 0; i < 16; i++) begin
                step(i < 8 ? 1'b0 : 1'b1);
                if ({btn_level, btn_press_pulse, press_count} !== {m_level, m_pulse, m_count}) bad++;
            end
            if (p == 255) begin
                checks++;
                if (press_count !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_255 got %0d exp 255", press_count);
                end
            end
        end
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL wrap_256 got %0d exp 0", press_count);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wrap_model got %0d mismatching cycles exp 0", bad);
        end
    endtask

    task automatic test_autorepeat();
        int got[$];
        int exp_edges[$];
`ifdef BTN_AUTOREPEAT_EN
        exp_edges = '{6, 16, 19, 22, 25, 28, 31};
`else
        exp_edges = '{6};
`endif
        btn_raw = 1'b1;
        do_reset();
        for (int i = 1; i <= 42; i++) begin
            step(i <= 30 ? 1'b0 : 1'b1);
            if (btn_press_pulse === 1'b1) got.push_back(i - 1);
            checks++;
            if ({btn_level, btn_press_pulse, press_count} !== {m_level, m_pulse, m_count}) begin
                errors++;
                $display("FAIL repeat_model step=%0d got %b/%b/%0d exp %b/%b/%0d", i, btn_level, btn_press_pulse, press_count, m_level, m_pulse, m_count);
            end
        end
        checks++;
        if (got != exp_edges) begin
            errors++;
            $display("FAIL repeat_edges got %p exp %p", got, exp_edges);
        end
        checks++;
        if (press_count !== 8'(exp_edges.size())) begin
            errors++;
            $display("FAIL repeat_count got %0d exp %0d", press_count, exp_edges.size());
        end
    endtask

    task automatic test_random();
        int bad;
        bit lvl;
        btn_raw = 1'b1;
        do_reset();
        bad = 0;
        lvl = 1'b1;
        for (int r = 0; r < 80; r++) begin
            lvl = !lvl;
            for (int i = 0; i < int'($urandom_range(1, 10)); i++) begin
                step(lvl);
                checks++;
                if ({btn_level, btn_press_pulse, press_count} !== {m_level, m_pulse, m_count}) begin
                    errors++;
                    bad++;
                    if (bad < 10)
                        $display("FAIL random_model run=%0d got %b/%b/%0d exp %b/%b/%0d", r, btn_level, btn_press_pulse, press_count, m_level, m_pulse, m_count);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        btn_raw = 1'b1;
        model_clear();
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_reset_mid_hold();
        test_autorepeat();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_debouncer.md
BTN_DEBOUNCER -- requirements
Module: btn_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, stable-input cycles needed to accept a level change (10 ms at 50 MHz), legal range 2..2^24-1.
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, held cycles before the first auto-repeat pulse (used only with BTN_AUTOREPEAT_EN).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000, cycles between later auto-repeat pulses (used only with BTN_AUTOREPEAT_EN).
REQ-004 SHALL have port clk_clk  input  1  system clock, single clock domain.
REQ-005 SHALL have port reset_reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port btn_raw  input  1  board pushbutton, active-low, asynchronous to clk_clk.
REQ-007 SHALL have port btn_level  output  1  debounced pressed state, 1 = pressed.
REQ-008 SHALL have port btn_press_pulse  output  1  one-cycle strobe per accepted press (and per repeat); drives the processor's button PIO input.
REQ-009 SHALL have port press_count  output  8  count of btn_press_pulse strobes since reset.

Function
REQ-010 SHALL pass btn_raw through a 2-flop synchronizer and invert it to give btn_sync (1 = pressed); no other logic may sample btn_raw.
REQ-011 SHALL implement FSM states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT, plus a 24-bit counter deb_cnt.
REQ-012 IDLE: btn_sync=1 -> PRESS_WAIT with deb_cnt=1; else stay.
REQ-013 PRESS_WAIT: btn_sync=0 -> IDLE with deb_cnt=0 (glitch rejected, no pulse); btn_sync=1 and deb_cnt=DEBOUNCE_CYCLES-1 -> HELD; else deb_cnt+1.
REQ-014 HELD: btn_sync=0 -> RELEASE_WAIT with deb_cnt=1; else stay.
REQ-015 RELEASE_WAIT: btn_sync=1 -> HELD with deb_cnt=0 (no new pulse); btn_sync=0 and deb_cnt=DEBOUNCE_CYCLES-1 -> IDLE; else deb_cnt+1.
REQ-016 btn_level SHALL be registered, 1 exactly while the state is HELD or RELEASE_WAIT.
REQ-017 btn_press_pulse SHALL be registered and high for exactly one cycle, the first cycle the state is HELD after PRESS_WAIT.
REQ-018 Latency: with btn_raw held low from clock edge k, btn_level and btn_press_pulse SHALL rise at edge k+2+DEBOUNCE_CYCLES.
REQ-019 press_count SHALL increment on the cycle following each btn_press_pulse and wrap 255 -> 0 with no saturation or flag.
REQ-020 Release SHALL never produce a pulse; btn_level SHALL fall DEBOUNCE_CYCLES+2 edges after btn_raw returns high and stays high.

Reset
REQ-021 reset_reset high SHALL asynchronously force state=IDLE, deb_cnt=0, synchronizer flops to released, btn_level=0, btn_press_pulse=0, press_count=0, repeat counter=0.
REQ-022 Reset asserted mid-debounce or mid-hold SHALL abandon the operation with no pulse. After deassertion a still-pressed button SHALL be debounced afresh and yield one pulse.

Configuration
REQ-023 Macro BTN_AUTOREPEAT_EN SHALL control auto-repeat.
REQ-024 With BTN_AUTOREPEAT_EN defined: while in HELD, a repeat counter SHALL issue btn_press_pulse REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles. The counter SHALL clear on leaving HELD, and repeats SHALL be suppressed in RELEASE_WAIT. Each repeat SHALL increment press_count.
REQ-025 Without BTN_AUTOREPEAT_EN: the repeat counter SHALL be absent and exactly one pulse SHALL occur per accepted press; REPEAT_DELAY and REPEAT_PERIOD SHALL be ignored.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-026 Clean press: btn_raw low from edge 0 for 20 cycles -> btn_level and btn_press_pulse rise at edge 6; pulse width 1 cycle; press_count=1 at edge 7.
REQ-027 Glitch: btn_raw low for 3 cycles, then high -> no pulse, btn_level stays 0, press_count=0.
REQ-028 Bounce: btn_raw toggles every 2 cycles for 12 cycles then held low -> exactly one pulse, 6 edges after the final falling transition.
REQ-029 Reset mid-hold: reset_reset pulsed while in HELD with btn_raw low -> outputs clear immediately; one new pulse 6 edges after deassertion; press_count=1.
REQ-030 Wrap: 256 clean presses -> press_count reads 0.
REQ-031 Auto-repeat (macro defined): btn_raw held low 30 cycles from edge 0 -> pulses at edges 6, 16, 19, 22, 25, 28, 31; without the macro only edge 6.
